display_hold_timer: RTL and testbench
=====================================

# display_hold_timer

Parametrised display-hold controller for the FSMD result path. Captures a result word on a `done_tick` pulse and presents it on `dout` for a fixed, exact number of clock cycles using an internal prescaler and hold counter. Results that arrive during a hold are queued in a one-entry pending buffer. The block sits between the datapath's completion strobe and the seven-segment/LED display driver.

## Interface
- `DATA_W`, 16: width of the captured result word.
- `DIV`, 16777216: prescaler period in clock cycles; must be ≥ 2. Counter width is `$clog2(DIV)`.
- `HOLD_TICKS`, 4: hold length in prescaler periods; must be ≥ 1.

- `clk`  in  1: sole clock; all logic on the rising edge.
- `reset_n`  in  1: synchronous, active-low reset.
- `done_tick`  in  1: single-cycle result-ready strobe.
- `din`  in  DATA_W: result word; sampled only when `done_tick`=1.
- `dout`  out  DATA_W: displayed word, registered.
- `hold`  out  1: high while a word is being held.
- `release_tick`  out  1: one-cycle pulse when a hold period expires.
- `overrun`  out  1: one-cycle pulse when a full pending entry is overwritten.

## Operation
- Reset (`reset_n`=0 at an edge) gives: state IDLE, `dout`=0, `hold`=0, `release_tick`=0, `overrun`=0, pending empty, `pcnt`=0, `tcnt`=0. Reset during HOLD discards the held and pending words. `dout` returns to 0.
- States: IDLE, HOLD.
- **IDLE**
  - Counters are frozen at 0.
  - `done_tick` loads `dout`<=`din`, clears `pcnt` and `tcnt`, and moves to HOLD.
  - `dout` keeps its last value while idle.
- **HOLD**
  - `pcnt` counts 0..DIV-1 and wraps.
  - When `pcnt`=DIV-1, `tcnt` increments.
  - Expiry condition: `tcnt`=HOLD_TICKS-1 and `pcnt`=DIV-1.
- **On expiry**
  - `release_tick` is pulsed.
  - If a word is pending, it loads into `dout`, the pending entry clears, counters restart at 0, and the state stays HOLD (`hold` stays 1).
  - Otherwise the state moves to IDLE.
- **`done_tick` in HOLD, not at expiry**
  - Pending empty: `din` is stored into pending.
  - Pending full: `din` overwrites pending (newest wins) and `overrun` is pulsed.
- **`done_tick` on the expiry cycle**
  - Pending empty: `din` bypasses pending and goes straight to `dout`. Counters restart and the state stays HOLD.
  - Pending full: the pending word goes to `dout` and `din` goes into pending. No `overrun`.
- The prescaler never runs in IDLE. Every hold starts from `pcnt`=0, so hold length is exact.

## Timing
- `done_tick` at edge t in IDLE: `dout`=`din` and `hold`=1 from cycle t+1.
- `hold` stays high for exactly HOLD_TICKS·DIV cycles (t+1 .. t+HOLD_TICKS·DIV).
- Expiry is detected at cycle t+HOLD_TICKS·DIV. At t+HOLD_TICKS·DIV+1:
  - `release_tick`=1 for one cycle;
  - `hold`=0, or `dout` shows the next word with `hold` still 1.
- All outputs are registered. There is no combinational path from inputs to outputs.
- `overrun` is high in the cycle after the offending `done_tick`.

## Configuration
- `HOLD_RETRIGGER_EN` defined:
  - `done_tick` in HOLD immediately loads `dout`<=`din` and restarts `pcnt`/`tcnt` at 0.
  - The pending buffer is not built. `overrun` is tied to 0.
  - Expiry always goes to IDLE.
- Not defined: pending-buffer behaviour as described under Operation.

## Test plan
Bench parameters: DIV=4, HOLD_TICKS=3 (12-cycle hold), DATA_W=16.

- **Reset values.** Hold `reset_n`=0 for 3 cycles, then release. Required: `dout`=0, `hold`=0, `release_tick`=0 and `overrun`=0 at every sampled cycle.
- **Single hold.** `done_tick` with `din`=0x1234 at cycle 10. Required: `dout`=0x1234 and `hold`=1 over cycles 11–22; `release_tick`=1 only at cycle 23; `hold`=0 from cycle 23; `dout` still 0x1234.
- **Queued word.** 0xAAAA at cycle 10, 0xBBBB at cycle 15. Required: `dout`=0xAAAA for cycles 11–22; `dout`=0xBBBB and `hold`=1 for cycles 23–34; `release_tick` at 23 and 35.
- **Overrun.** 0x0001 at cycle 10, 0x0002 at 12, 0x0003 at 14. Required: `overrun`=1 only at cycle 15; the second word shown is 0x0003; 0x0002 never appears.
- **Expiry collision.** 0x00AA at cycle 10, 0x00BB at cycle 22 (the expiry cycle). Required: `dout`=0x00BB from cycle 23; `hold` never drops; `release_tick`=1 at 23; no `overrun`.
- **Reset mid-hold.** `reset_n`=0 at cycle 16 during a hold with a word pending. Required: all outputs 0 from cycle 17; the pending word is never displayed.
- **Retrigger build.** With `HOLD_RETRIGGER_EN` defined, rerun the queued-word case. Required: `dout`=0xBBBB from cycle 16; `hold` high cycles 11–27; `release_tick` only at 28.

Source files
------------

// File: rtl/display_hold_timer.sv
`default_nettype none
// ============================================================================
// Module   : display_hold_timer
// Brief    : Captures a result word on done_tick and holds it on dout for
//            exactly HOLD_TICKS*DIV cycles, with a one-entry pending buffer.
//            Optional macro HOLD_RETRIGGER_EN: done_tick restarts the hold.
// Revision : 1.0 - initial release
// ============================================================================
module display_hold_timer #(
    parameter int DATA_W     = 16,
    parameter int DIV        = 16777216,
    parameter int HOLD_TICKS = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              done_tick,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              hold,
    output logic              release_tick,
    output logic              overrun
);

    localparam int c_PCNT_W = $clog2(DIV);
    localparam int c_TCNT_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [c_PCNT_W-1:0] c_PCNT_MAX = c_PCNT_W'(DIV - 1);
    localparam logic [c_TCNT_W-1:0] c_TCNT_MAX = c_TCNT_W'(HOLD_TICKS - 1);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_HOLD = 1'b1;

    logic [0:0]          r_state, w_state_next;
    logic [c_PCNT_W-1:0] r_pcnt, w_pcnt_next;
    logic [c_TCNT_W-1:0] r_tcnt, w_tcnt_next;
    logic [DATA_W-1:0]   r_dout, w_dout_next;
    logic                r_release, w_release_next;
    logic                w_expire;
`ifndef HOLD_RETRIGGER_EN
    logic [DATA_W-1:0]   r_pend, w_pend_next;
    logic                r_pend_vld, w_pend_vld_next;
    logic                r_overrun, w_overrun_next;
`endif

    assign w_expire = (r_state == c_ST_HOLD) && (r_pcnt == c_PCNT_MAX) && (r_tcnt == c_TCNT_MAX);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= c_ST_IDLE;
            r_pcnt     <= '0;
            r_tcnt     <= '0;
            r_dout     <= '0;
            r_release  <= 1'b0;
`ifndef HOLD_RETRIGGER_EN
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            r_overrun  <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_next;
            r_pcnt     <= w_pcnt_next;
            r_tcnt     <= w_tcnt_next;
            r_dout     <= w_dout_next;
            r_release  <= w_release_next;
`ifndef HOLD_RETRIGGER_EN
            r_pend     <= w_pend_next;
            r_pend_vld <= w_pend_vld_next;
            r_overrun  <= w_overrun_next;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (done_tick) w_state_next = c_ST_HOLD;
            end
            c_ST_HOLD: begin
`ifdef HOLD_RETRIGGER_EN
                if (w_expire && !done_tick) w_state_next = c_ST_IDLE;
`else
                if (w_expire && !r_pend_vld && !done_tick) w_state_next = c_ST_IDLE;
`endif
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    // Counter, display and pulse logic
    always_comb begin
        w_pcnt_next    = '0;
        w_tcnt_next    = '0;
        w_dout_next    = r_dout;
        w_release_next = 1'b0;
`ifndef HOLD_RETRIGGER_EN
        w_pend_next     = r_pend;
        w_pend_vld_next = r_pend_vld;
        w_overrun_next  = 1'b0;
`endif
        if (r_state == c_ST_IDLE) begin
            if (done_tick) w_dout_next = din;
        end else begin
            if (r_pcnt == c_PCNT_MAX) begin
                w_tcnt_next = r_tcnt + c_TCNT_W'(1);
            end else begin
                w_pcnt_next = r_pcnt + c_PCNT_W'(1);
                w_tcnt_next = r_tcnt;
            end
            // Every hold, including back-to-back ones, restarts from zero
            if (w_expire) begin
                w_release_next = 1'b1;
                w_pcnt_next    = '0;
                w_tcnt_next    = '0;
            end
`ifdef HOLD_RETRIGGER_EN
            if (done_tick) begin
                w_dout_next = din;
                w_pcnt_next = '0;
                w_tcnt_next = '0;
            end
`else
            if (w_expire) begin
                if (r_pend_vld) begin
                    w_dout_next     = r_pend;
                    w_pend_vld_next = done_tick;
                    if (done_tick) w_pend_next = din;
                end else if (done_tick) begin
                    w_dout_next = din;
                end
            end else if (done_tick) begin
                w_pend_next     = din;
                w_pend_vld_next = 1'b1;
                w_overrun_next  = r_pend_vld;
            end
`endif
        end
    end

    assign dout         = r_dout;
    assign hold         = (r_state == c_ST_HOLD);
    assign release_tick = r_release;
`ifdef HOLD_RETRIGGER_EN
    assign overrun      = 1'b0;
`else
    assign overrun      = r_overrun;
`endif

endmodule
`default_nettype wire

// File: tb/tb_display_hold_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_hold_timer
// Brief    : Directed scoreboard bench for display_hold_timer (DIV=4,
//            HOLD_TICKS=3, 12-cycle hold).
// Revision : 1.0 - initial release
// ============================================================================
module tb_display_hold_timer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        done_tick = 1'b0;
    logic [15:0] din = '0;
    logic [15:0] dout;
    logic        hold;
    logic        release_tick;
    logic        overrun;

    display_hold_timer #(
        .DATA_W    (16),
        .DIV       (4),
        .HOLD_TICKS(3)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .done_tick   (done_tick),
        .din         (din),
        .dout        (dout),
        .hold        (hold),
        .release_tick(release_tick),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] dout;
        logic        hold;
        logic        rel;
        logic        ovr;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    // Expected outputs during cycle c, written straight from the scenario timelines
    function automatic exp_t model(input int scn, input int c);
        exp_t e;
        e = '0;
        case (scn)
            1: begin
                if (c >= 11) e.dout = 16'h1234;
                e.hold = (c >= 11 && c <= 22);
                e.rel  = (c == 23);
            end
            2: begin
                if (c >= 11) e.dout = 16'hAAAA;
                if (c >= 23) e.dout = 16'hBBBB;
                e.hold = (c >= 11 && c <= 34);
                e.rel  = (c == 23 || c == 35);
            end
            3: begin
                if (c >= 11) e.dout = 16'h0001;
                if (c >= 23) e.dout = 16'h0003;
                e.hold = (c >= 11 && c <= 34);
                e.rel  = (c == 23 || c == 35);
                e.ovr  = (c == 15);
            end
            4: begin
                if (c >= 11) e.dout = 16'h00AA;
                if (c >= 23) e.dout = 16'h00BB;
                e.hold = (c >= 11 && c <= 34);
                e.rel  = (c == 23 || c == 35);
            end
            5: begin
                if (c >= 11 && c <= 16) e.dout = 16'h1111;
                if (c >= 21) e.dout = 16'h3333;
                e.hold = (c >= 11 && c <= 16) || (c >= 21 && c <= 32);
                e.rel  = (c == 33);
            end
            6: begin
                if (c >= 11) e.dout = 16'hAAAA;
                if (c >= 16) e.dout = 16'hBBBB;
                e.hold = (c >= 11 && c <= 27);
                e.rel  = (c == 28);
            end
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic stim(input int scn, input int c, output logic d, output logic [15:0] w,
                        output logic r);
        d = 1'b0;
        w = 16'h0000;
        r = 1'b1;
        case (scn)
            1: if (c == 10) begin d = 1'b1; w = 16'h1234; end
            2, 6: begin
                if (c == 10) begin d = 1'b1; w = 16'hAAAA; end
                if (c == 15) begin d = 1'b1; w = 16'hBBBB; end
            end
            3: begin
                if (c == 10) begin d = 1'b1; w = 16'h0001; end
                if (c == 12) begin d = 1'b1; w = 16'h0002; end
                if (c == 14) begin d = 1'b1; w = 16'h0003; end
            end
            4: begin
                if (c == 10) begin d = 1'b1; w = 16'h00AA; end
                if (c == 22) begin d = 1'b1; w = 16'h00BB; end
            end
            5: begin
                if (c == 10) begin d = 1'b1; w = 16'h1111; end
                if (c == 13) begin d = 1'b1; w = 16'h2222; end
                if (c == 16 || c == 17) r = 1'b0;
                if (c == 20) begin d = 1'b1; w = 16'h3333; end
            end
            default: ;
        endcase
    endtask

    task automatic compare(input int scn, input int c);
        exp_t e;
        if (sb.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL sb_empty scn=%0d c=%0d got empty queue, need entry", scn, c);
        end else begin
            e = sb.pop_front();
            n_assert++;
            assert (dout === e.dout) else begin
                n_fail++;
                $error("FAIL dout scn=%0d c=%0d got %h exp %h", scn, c, dout, e.dout);
            end
            n_assert++;
            assert (hold === e.hold) else begin
                n_fail++;
                $error("FAIL hold scn=%0d c=%0d got %b exp %b", scn, c, hold, e.hold);
            end
            n_assert++;
            assert (release_tick === e.rel) else begin
                n_fail++;
                $error("FAIL release_tick scn=%0d c=%0d got %b exp %b", scn, c, release_tick, e.rel);
            end
            n_assert++;
            assert (overrun === e.ovr) else begin
                n_fail++;
                $error("FAIL overrun scn=%0d c=%0d got %b exp %b", scn, c, overrun, e.ovr);
            end
        end
    endtask

    task automatic run_scn(input int scn, input int last);
        logic        d;
        logic [15:0] w;
        logic        r;
        reset_n   = 1'b0;
        done_tick = 1'b0;
        din       = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(exp_t'('0));
            @(posedge clk);
            #1;
            compare(scn, -3 + i);
        end
        for (int c = 0; c <= last; c++) begin
            stim(scn, c, d, w, r);
            reset_n   = r;
            done_tick = d;
            din       = w;
            sb.push_back(model(scn, c + 1));
            @(posedge clk);
            #1;
            compare(scn, c + 1);
        end
        done_tick = 1'b0;
    endtask

    initial begin
`ifdef HOLD_RETRIGGER_EN
        run_scn(1, 40);
        run_scn(6, 40);
`else
        run_scn(1, 30);
        run_scn(2, 40);
        run_scn(3, 40);
        run_scn(4, 40);
        run_scn(5, 40);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
